// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
//
// Shared constants for the MIPS instruction fetch stage:
//   PC_RESET_DEFAULT  default program counter after reset (MIPS text base)
//   INSTR_W           instruction word width
//   NOP               instruction value shown in the output slot when empty
//   ST_*              fetch FSM state encoding (plain constants so older
//                     tools and netlists see a fixed encoding)
//   fetch_state_t     type used for the FSM state register
//   next_word_pc      sequential successor of a fetch address
//
// No ports; imported by every file of the fetch stage.
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = '0;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] fetch_state_t;

  // IDLE  : single cycle after reset, no request yet
  // WAIT  : a memory request is being presented (imem_req=1)
  // BLOCK : skid buffer holds a word, requests paused until decode drains
  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_WAIT  = 2'd1;
  localparam fetch_state_t ST_BLOCK = 2'd2;

  // Successor of a 32-bit fetch address; wraps 0xFFFFFFFC -> 0x00000000.
  function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//
// Instruction memory read bus between the fetch stage and instruction memory.
//   imem_req    fetch -> mem   read request, held until imem_ack
//   imem_addr   fetch -> mem   word address, stable while imem_req=1 and no ack
//   imem_ack    mem -> fetch   read complete (same cycle as req or later)
//   imem_rdata  mem -> fetch   instruction word, valid while imem_ack=1
//
// Modports:
//   master  used by the fetch stage
//   slave   used by the instruction memory (or a memory model)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/instr_skid_buf.sv
// ---------------------------------------------------------------------------
// instr_skid_buf
//
// One-entry {instruction word, pc} holding register used when a word returns
// from memory while the decode slot is occupied and stalled.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset (empties the buffer)
//   flush      in   discard the held entry (highest priority)
//   push       in   capture push_word/push_pc; only issued while empty
//   pop        in   release the held entry; only issued while full
//   push_word  in   word to capture
//   push_pc    in   pc of the word to capture
//   full       out  an entry is held
//   pop_word   out  held word
//   pop_pc     out  pc of held word
// ---------------------------------------------------------------------------
module instr_skid_buf
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [INSTR_W-1:0] push_word,
  input  logic [ADDR_W-1:0]  push_pc,
  output logic               full,
  output logic [INSTR_W-1:0] pop_word,
  output logic [ADDR_W-1:0]  pop_pc
);

  logic               full_reg;
  logic [INSTR_W-1:0] word_reg;
  logic [ADDR_W-1:0]  pc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      word_reg <= NOP;
      pc_reg   <= '0;
    end else if (flush) begin
      // Redirect: whatever is held belongs to the wrong path.
      full_reg <= 1'b0;
    end else if (push) begin
      full_reg <= 1'b1;
      word_reg <= push_word;
      pc_reg   <= push_pc;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  assign full     = full_reg;
  assign pop_word = word_reg;
  assign pop_pc   = pc_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// MIPS instruction fetch stage. Owns the PC, reads instruction memory one
// word at a time over a req/ack handshake, and hands each word with its PC
// to the decoder through a registered output slot. A one-entry skid buffer
// catches a word that returns while decode is stalled; a redirect from the
// branch/jump resolution logic flushes the pipeline and restarts at the
// target, dropping the reply of any request already in flight.
//
// Parameters:
//   ADDR_W    PC / memory address width
//   PC_RESET  PC after reset
//
// Ports:
//   clk             in   clock, all state on rising edge
//   rst_n           in   synchronous active-low reset
//   stall           in   decode cannot accept instr this cycle
//   redirect_valid  in   one-cycle pulse, branch/jump taken
//   redirect_pc     in   new fetch address (bits [1:0] ignored)
//   imem            if   instruction memory bus (master side)
//   instr           out  instruction word to decode
//   instr_pc        out  PC of instr
//   instr_pc4       out  instr_pc + 4 (link value / branch base)
//   instr_valid     out  instr valid; consumed on any cycle with stall=0
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  instr_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [ADDR_W-1:0]   instr_pc4,
  output logic                instr_valid
);

  // ---- state -------------------------------------------------------------
  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;          // address of next word to fetch
  logic [ADDR_W-1:0]  addr_reg, addr_next;      // address on the memory bus
  logic               squash_reg, squash_next;  // drop the next ack
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic [ADDR_W-1:0]  instr_pc_reg, instr_pc_next;
  logic               instr_valid_reg, instr_valid_next;

  // ---- skid buffer interface ---------------------------------------------
  logic               skid_push, skid_pop, skid_flush, skid_full;
  logic [INSTR_W-1:0] skid_word;
  logic [ADDR_W-1:0]  skid_pc;

  // ---- handshake decode --------------------------------------------------
  logic              req;
  logic              fire;         // request completes this cycle
  logic              word_accept;  // returning word is on the live path
  logic              slot_free;    // output slot can take a word at this edge
  logic [ADDR_W-1:0] redirect_target;

  assign req             = (state_reg == ST_WAIT);
  assign fire            = req && imem.imem_ack;
  assign word_accept     = fire && !squash_reg && !redirect_valid;
  assign slot_free       = !instr_valid_reg || !stall;
  assign redirect_target = redirect_pc & ~ADDR_W'(3);

  // The bus address may only move when no request is pending; otherwise it
  // tracks the PC so each new request starts at the current fetch address.
  assign addr_next = (req && !imem.imem_ack) ? addr_reg : pc_next;

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    squash_next      = squash_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    instr_valid_next = instr_valid_reg;
    skid_push        = 1'b0;
    skid_pop         = 1'b0;
    skid_flush       = 1'b0;

    if (redirect_valid) begin
      // Redirect wins over stall and ack: everything already fetched is
      // on the wrong path.
      pc_next          = redirect_target;
      instr_valid_next = 1'b0;
      skid_flush       = 1'b1;
      state_next       = ST_WAIT;
      // A request still waiting for its ack must run to completion on the
      // old address; its reply is dropped. A request acked in this very
      // cycle is simply discarded. Re-redirecting while squashing keeps
      // exactly one pending drop.
      squash_next      = req && !imem.imem_ack;
    end else begin
      if (fire) begin
        squash_next = 1'b0;
        if (!squash_reg) begin
          pc_next = pc_reg + ADDR_W'(4);
        end
      end

      if (slot_free) begin
        if (skid_full) begin
          // Older word first: the skid entry precedes anything new.
          instr_next       = skid_word;
          instr_pc_next    = skid_pc;
          instr_valid_next = 1'b1;
          skid_pop         = 1'b1;
        end else if (word_accept) begin
          instr_next       = imem.imem_rdata;
          instr_pc_next    = addr_reg;
          instr_valid_next = 1'b1;
        end else begin
          instr_valid_next = 1'b0;
        end
      end else if (word_accept) begin
        skid_push = 1'b1;
      end

      case (state_reg)
        ST_IDLE:  state_next = ST_WAIT;
        ST_WAIT:  if (word_accept && !slot_free) state_next = ST_BLOCK;
        ST_BLOCK: if (slot_free) state_next = ST_WAIT;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= PC_RESET;
      addr_reg        <= PC_RESET;
      squash_reg      <= 1'b0;
      instr_reg       <= NOP;
      instr_pc_reg    <= PC_RESET;
      instr_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      addr_reg        <= addr_next;
      squash_reg      <= squash_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
      instr_valid_reg <= instr_valid_next;
    end
  end

  instr_skid_buf #(
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (skid_flush),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_word (imem.imem_rdata),
    .push_pc   (addr_reg),
    .full      (skid_full),
    .pop_word  (skid_word),
    .pop_pc    (skid_pc)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr_reg;

  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_pc4   = instr_pc_reg + ADDR_W'(4);
  assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives the fetch stage with a random-latency memory model and random
// stall/redirect traffic. The reference is the architectural fetch stream:
// the decoder must see consecutive word addresses starting at the reset PC,
// restarting at (target & ~3) after every redirect, each carrying the memory
// contents of its address. Directed phases cover the listed corner cases.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam logic [31:0] PC_RST = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        instr_valid;

  instr_fetch_unit_if #(.ADDR_W(32)) imem_bus ();

  instr_fetch_unit #(
    .ADDR_W   (32),
    .PC_RESET (PC_RST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc4      (instr_pc4),
    .instr_valid    (instr_valid)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_pc;
  int          delivered;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] req_addr;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // One clock of stimulus, called at a falling edge before anything is driven.
  task automatic cycle(input int stall_pct, input int lat_min, input int lat_max,
                       input int redir_pct, input bit force_redir,
                       input logic [31:0] force_target);
    bit          redir;
    logic [31:0] tgt;
    // memory model
    if (imem_bus.imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = int'($urandom_range(lat_max, lat_min));
        req_addr = imem_bus.imem_addr;
      end else begin
        check("addr_hold", imem_bus.imem_addr, req_addr);
      end
      if (mem_cnt == 0) begin
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
        mem_busy            = 1'b0;
      end else begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = $urandom();
        mem_cnt--;
      end
    end else begin
      // Spurious acks with no request must be ignored.
      mem_busy            = 1'b0;
      imem_bus.imem_ack   = 1'($urandom_range(1, 0));
      imem_bus.imem_rdata = $urandom();
    end
    // decoder / branch unit
    stall          = (int'($urandom_range(99, 0)) < stall_pct);
    redir          = force_redir || (int'($urandom_range(99, 0)) < redir_pct);
    tgt            = force_redir ? force_target : $urandom();
    redirect_valid = redir;
    redirect_pc    = tgt;
    // reference: architectural fetch stream
    if (instr_valid) begin
      check("instr_pc", instr_pc, exp_pc);
      check("instr", instr, mem_word(exp_pc));
      check("instr_pc4", instr_pc4, exp_pc + 32'd4);
      if (!stall) begin
        $display("[TB] deliver pc=%08h instr=%08h", instr_pc, instr);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    if (redir) exp_pc = tgt & ~32'h3;
  endtask

  task automatic run(input int n, input int stall_pct, input int lat_min,
                     input int lat_max, input int redir_pct);
    for (int i = 0; i < n; i++) begin
      cycle(stall_pct, lat_min, lat_max, redir_pct, 1'b0, 32'h0);
      @(negedge clk);
    end
  endtask

  // Enters and leaves at a falling edge; ends with the first request visible.
  task automatic do_reset();
    rst_n             = 1'b0;
    stall             = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;
    imem_bus.imem_ack = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, PC_RST);
    check("rst_instr_pc4", instr_pc4, PC_RST + 32'd4);
    @(negedge clk);
    rst_n    = 1'b1;
    mem_busy = 1'b0;
    exp_pc   = PC_RST;
    @(negedge clk);
    check("first_req", 32'(imem_bus.imem_req), 32'd1);
    check("first_addr", imem_bus.imem_addr, PC_RST);
  endtask

  initial begin
    int d0;
    rst_n               = 1'b0;
    stall               = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    delivered           = 0;
    mem_busy            = 1'b0;
    mem_cnt             = 0;
    req_addr            = 32'h0;
    exp_pc              = PC_RST;
    @(negedge clk);

    // 1: zero-wait memory, no stall -> one instruction per cycle
    do_reset();
    delivered = 0;
    run(20, 0, 0, 0, 0);
    check("t1_rate", 32'(delivered), 32'd19);

    // 2: stall 4 cycles -> request drops once skid fills, then drain in order
    for (int k = 0; k < 4; k++) begin
      if (k >= 1) check("t2_req_drop", 32'(imem_bus.imem_req), 32'd0);
      cycle(100, 0, 0, 0, 1'b0, 32'h0);
      @(negedge clk);
    end
    d0 = delivered;
    run(10, 0, 0, 0, 0);
    check("t2_drain", 32'(delivered - d0), 32'd10);

    // 3: 3-cycle memory, redirect one cycle after request -> stale word dropped
    do_reset();
    cycle(0, 3, 3, 0, 1'b0, 32'h0);
    @(negedge clk);
    cycle(0, 3, 3, 0, 1'b1, 32'h0040_0100);
    @(negedge clk);
    d0 = delivered;
    run(20, 0, 3, 3, 0);
    check("t3_progress", 32'(delivered > d0), 32'd1);

    // 4: redirect while blocked with stall held -> slot empties, req at target
    do_reset();
    run(5, 0, 0, 0, 0);
    cycle(100, 0, 0, 0, 1'b0, 32'h0);
    @(negedge clk);
    cycle(100, 0, 0, 0, 1'b0, 32'h0);
    @(negedge clk);
    cycle(100, 0, 0, 0, 1'b1, 32'h0040_0802);
    @(negedge clk);
    check("t4_valid", 32'(instr_valid), 32'd0);
    check("t4_req", 32'(imem_bus.imem_req), 32'd1);
    check("t4_addr", imem_bus.imem_addr, 32'h0040_0800);
    run(10, 0, 0, 0, 0);

    // 5: redirect near the top of memory -> PC wraps to zero
    cycle(0, 0, 0, 0, 1'b1, 32'hFFFF_FFFE);
    @(negedge clk);
    d0 = delivered;
    run(6, 0, 0, 0, 0);
    check("t5_wrap_count", 32'(delivered - d0), 32'd5);

    // 6: reset with a request outstanding
    cycle(0, 3, 3, 0, 1'b0, 32'h0);
    @(negedge clk);
    do_reset();

    // random traffic
    d0 = delivered;
    for (int blk = 0; blk < 6; blk++) begin
      if (blk == 3) do_reset();
      run(400, int'($urandom_range(60, 0)), 0, int'($urandom_range(3, 0)),
          int'($urandom_range(10, 0)));
    end
    check("rand_progress", 32'(delivered - d0 >= 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
